// File: rtl/mem_operator.sv
// mem_operator: byte-serial load/store unit behind the CSU.
// One byte per cycle, little-endian, with I/O store backpressure.
`timescale 1ns/1ps
module mem_operator #(
  parameter int CSU_SIZE_BITS = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_pipline,
  input  logic                     is_executing,
  input  logic                     executing_ins_type,
  input  logic [CSU_SIZE_BITS-1:0] exec_ins_id,
  input  logic [6:0]               exec_opcode,
  input  logic [2:0]               exec_funct3,
  input  logic [31:0]              exec_imm_val,
  input  logic [31:0]              exec_rs1,
  input  logic [31:0]              exec_rs2,
  input  logic [31:0]              exec_PC,
  input  logic                     exec_is_compressed_ins,
  output logic                     mo_busy,
  output logic                     mo_rdy,
  output logic [31:0]              mo_res,
  output logic [CSU_SIZE_BITS-1:0] mo_res_ins_id,
  output logic [31:0]              mo_completed_mo_resulting_PC,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [31:0]              mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  k, k_nxt;
  logic [31:0] acc, acc_nxt;
  logic [31:0] addr, rs2, pc_res;
  logic [2:0]  f3;
  logic        ld, st;
  logic [CSU_SIZE_BITS-1:0] id;
  logic        wr_q;

  logic        accept;
  logic [31:0] c_addr, c_rs2, c_pc;
  logic [2:0]  c_f3, c_n;
  logic        c_ld, c_st, c_io;
  logic [CSU_SIZE_BITS-1:0] c_id;

  logic        rdy_nxt, wr_nxt;
  logic [31:0] res_nxt, a_nxt, pc_nxt, ext;
  logic [7:0]  dout_nxt;
  logic [CSU_SIZE_BITS-1:0] rid_nxt;
  logic [1:0]  bi;

  assign accept = (state == IDLE) && is_executing
               && executing_ins_type
               && !flush_pipline && rdy_in;
  assign mo_busy = (state != IDLE);
  assign mem_wr  = wr_q & rdy_in;

  // Operation view: the dispatch being accepted, else the latched one
  always_comb begin
    c_addr = addr;
    c_rs2  = rs2;
    c_pc   = pc_res;
    c_f3   = f3;
    c_ld   = ld;
    c_st   = st;
    c_id   = id;
    if (accept) begin
      c_addr = exec_rs1 + exec_imm_val;
      c_rs2  = exec_rs2;
      c_pc   = exec_PC + (exec_is_compressed_ins ? 32'd2 : 32'd4);
      c_f3   = exec_funct3;
      c_ld   = (exec_opcode == OP_LOAD);
      c_st   = (exec_opcode == OP_STORE);
      c_id   = exec_ins_id;
    end
    c_io = (c_addr[17:16] == 2'b11);
    unique case (c_f3[1:0])
      2'b00:   c_n = 3'd1;
      2'b01:   c_n = 3'd2;
      default: c_n = 3'd4;
    endcase
  end

  // Next state, byte counter, accumulator and next registered outputs
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    acc_nxt   = acc;
    rdy_nxt   = 1'b0;
    wr_nxt    = 1'b0;
    a_nxt     = '0;
    dout_nxt  = '0;
    res_nxt   = mo_res;
    rid_nxt   = mo_res_ins_id;
    pc_nxt    = mo_completed_mo_resulting_PC;
    bi        = k[1:0] - 2'd1;
    ext       = '0;
    if (flush_pipline) begin
      state_nxt = IDLE;
      k_nxt     = '0;
    end else if (!rdy_in) begin
      rdy_nxt  = mo_rdy;
      wr_nxt   = wr_q;
      a_nxt    = mem_a;
      dout_nxt = mem_dout;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            k_nxt     = '0;
            acc_nxt   = '0;
            state_nxt = (c_ld | c_st) ? ACCESS : DONE;
          end
        end
        ACCESS: begin
          if (ld) begin
            if (k != 3'd0)
              acc_nxt = acc
                | ({24'd0, mem_din} << {bi, 3'b000});
            k_nxt = k + 3'd1;
            if (k == c_n) begin
              state_nxt = DONE;
              k_nxt     = '0;
            end
          end else if (wr_q) begin
            k_nxt = k + 3'd1;
            if (k_nxt == c_n) begin
              state_nxt = DONE;
              k_nxt     = '0;
            end
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
      if (state_nxt == ACCESS && k_nxt < c_n) begin
        a_nxt = c_addr + {29'd0, k_nxt};
        if (c_st) begin
          unique case (k_nxt[1:0])
            2'd0:    dout_nxt = c_rs2[7:0];
            2'd1:    dout_nxt = c_rs2[15:8];
            2'd2:    dout_nxt = c_rs2[23:16];
            default: dout_nxt = c_rs2[31:24];
          endcase
          wr_nxt = ~(c_io & io_buffer_full);
        end
      end
      unique case (c_f3[1:0])
        2'b00: ext = {{24{~c_f3[2] & acc_nxt[7]}},
                      acc_nxt[7:0]};
        2'b01: ext = {{16{~c_f3[2] & acc_nxt[15]}},
                      acc_nxt[15:0]};
        default: ext = acc_nxt;
      endcase
      if (state_nxt == DONE) begin
        rdy_nxt = 1'b1;
        res_nxt = c_ld ? ext : '0;
        rid_nxt = c_id;
        pc_nxt  = c_pc;
      end
    end
  end

  // FSM state, byte counter and load accumulator
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      k     <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      acc   <= acc_nxt;
    end
  end

  // Latch the dispatched operation on accept
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      addr   <= '0;
      rs2    <= '0;
      pc_res <= '0;
      f3     <= '0;
      ld     <= 1'b0;
      st     <= 1'b0;
      id     <= '0;
    end else if (accept) begin
      addr   <= c_addr;
      rs2    <= c_rs2;
      pc_res <= c_pc;
      f3     <= c_f3;
      ld     <= c_ld;
      st     <= c_st;
      id     <= c_id;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mo_rdy                       <= 1'b0;
      mo_res                       <= '0;
      mo_res_ins_id                <= '0;
      mo_completed_mo_resulting_PC <= '0;
      mem_a                        <= '0;
      mem_dout                     <= '0;
      wr_q                         <= 1'b0;
    end else begin
      mo_rdy                       <= rdy_nxt;
      mo_res                       <= res_nxt;
      mo_res_ins_id                <= rid_nxt;
      mo_completed_mo_resulting_PC <= pc_nxt;
      mem_a                        <= a_nxt;
      mem_dout                     <= dout_nxt;
      wr_q                         <= wr_nxt;
    end
  end
endmodule

// File: tb/tb_mem_operator.sv
// tb_mem_operator: directed vectors for mem_operator.
// Synchronous byte RAM model, frozen together with rdy_in.
`timescale 1ns/1ps
module tb_mem_operator;
  localparam int W = 3;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          rdy_in = 1'b1;
  logic          flush_pipline = 1'b0;
  logic          is_executing = 1'b0;
  logic          executing_ins_type = 1'b0;
  logic [W-1:0]  exec_ins_id = '0;
  logic [6:0]    exec_opcode = '0;
  logic [2:0]    exec_funct3 = '0;
  logic [31:0]   exec_imm_val = '0;
  logic [31:0]   exec_rs1 = '0;
  logic [31:0]   exec_rs2 = '0;
  logic [31:0]   exec_PC = '0;
  logic          exec_is_compressed_ins = 1'b0;
  logic          mo_busy;
  logic          mo_rdy;
  logic [31:0]   mo_res;
  logic [W-1:0]  mo_res_ins_id;
  logic [31:0]   mo_completed_mo_resulting_PC;
  logic [7:0]    mem_din = '0;
  logic [7:0]    mem_dout;
  logic [31:0]   mem_a;
  logic          mem_wr;
  logic          io_buffer_full = 1'b0;

  always #5 clk_in = ~clk_in;

  mem_operator #(.CSU_SIZE_BITS(W)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .flush_pipline(flush_pipline),
    .is_executing(is_executing),
    .executing_ins_type(executing_ins_type),
    .exec_ins_id(exec_ins_id),
    .exec_opcode(exec_opcode),
    .exec_funct3(exec_funct3),
    .exec_imm_val(exec_imm_val),
    .exec_rs1(exec_rs1),
    .exec_rs2(exec_rs2),
    .exec_PC(exec_PC),
    .exec_is_compressed_ins(exec_is_compressed_ins),
    .mo_busy(mo_busy),
    .mo_rdy(mo_rdy),
    .mo_res(mo_res),
    .mo_res_ins_id(mo_res_ins_id),
    .mo_completed_mo_resulting_PC(mo_completed_mo_resulting_PC),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .mem_a(mem_a),
    .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  logic [7:0] mem [0:262143];
  logic [7:0] wr_seen [logic [31:0]];
  int         wr_cnt = 0;

  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (mem_wr) begin
        wr_seen[mem_a] = mem_dout;
        wr_cnt++;
      end
      mem_din <= mem[mem_a[17:0]];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wbyte(
    input logic [31:0] a);
    return wr_seen.exists(a) ?
      {24'd0, wr_seen[a]} : 32'hDEAD_BEEF;
  endfunction

  task automatic issue(input logic [6:0] op,
                       input logic [2:0] f3,
                       input logic [31:0] rs1,
                       input logic [31:0] imm,
                       input logic [31:0] rs2,
                       input logic [W-1:0] id,
                       input logic [31:0] pc,
                       input logic c);
    is_executing           = 1'b1;
    executing_ins_type     = 1'b1;
    exec_opcode            = op;
    exec_funct3            = f3;
    exec_rs1               = rs1;
    exec_imm_val           = imm;
    exec_rs2               = rs2;
    exec_ins_id            = id;
    exec_PC                = pc;
    exec_is_compressed_ins = c;
    @(posedge clk_in);
    #1;
    is_executing       = 1'b0;
    executing_ins_type = 1'b0;
  endtask

  logic [31:0] seen_a  [1:16];
  logic        seen_wr [1:16];

  task automatic run(input string tag,
                     input logic [31:0] er,
                     input logic [W-1:0] eid,
                     input logic [31:0] epc,
                     input int elat);
    int first = 0;
    int cnt = 0;
    logic [31:0] r = '0;
    logic [31:0] p = '0;
    logic [W-1:0] d = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk_in);
      seen_a[i]  = mem_a;
      seen_wr[i] = mem_wr;
      if (mo_rdy) begin
        cnt++;
        if (first == 0) begin
          first = i;
          r = mo_res;
          d = mo_res_ins_id;
          p = mo_completed_mo_resulting_PC;
        end
      end
    end
    chk({tag, "_lat"}, 32'(first), 32'(elat));
    chk({tag, "_rdycnt"}, 32'(cnt), 32'd1);
    chk({tag, "_res"}, r, er);
    chk({tag, "_id"}, 32'(d), 32'(eid));
    chk({tag, "_pc"}, p, epc);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
    mem[18'h104] = 8'h78;
    mem[18'h105] = 8'h56;
    mem[18'h106] = 8'h34;
    mem[18'h107] = 8'h12;
    mem[18'h500] = 8'h80;
    mem[18'h600] = 8'h01;
    mem[18'h601] = 8'h80;

    #1;
    chk("rst_rdy",  32'(mo_rdy),  32'd0);
    chk("rst_busy", 32'(mo_busy), 32'd0);
    chk("rst_a",    mem_a,        32'd0);
    chk("rst_wr",   32'(mem_wr),  32'd0);
    chk("rst_res",  mo_res,       32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    issue(LD, 3'b010, 32'h100, 32'h4, 32'h0,
          3'd5, 32'h40, 1'b0);
    run("lw", 32'h1234_5678, 3'd5, 32'h44, 6);
    for (int i = 0; i < 4; i++)
      chk("lw_a", seen_a[i+1], 32'h104 + 32'(i));
    chk("lw_a_end", seen_a[5], 32'h0);

    issue(LD, 3'b000, 32'h4F0, 32'h10, 32'h0,
          3'd1, 32'h100, 1'b0);
    run("lb", 32'hFFFF_FF80, 3'd1, 32'h104, 3);

    issue(LD, 3'b100, 32'h500, 32'h0, 32'h0,
          3'd2, 32'h200, 1'b1);
    run("lbu", 32'h0000_0080, 3'd2, 32'h202, 3);

    issue(LD, 3'b001, 32'h600, 32'h0, 32'h0,
          3'd4, 32'h300, 1'b0);
    run("lh", 32'hFFFF_8001, 3'd4, 32'h304, 4);

    base = wr_cnt;
    issue(ALU, 3'b000, 32'h100, 32'h0, 32'h0,
          3'd2, 32'h80, 1'b0);
    run("alu", 32'h0, 3'd2, 32'h84, 1);
    chk("alu_wcnt", 32'(wr_cnt - base), 32'd0);
    chk("alu_a", seen_a[1], 32'h0);

    base = wr_cnt;
    issue(ST, 3'b001, 32'h200, 32'hFFFF_FFFF,
          32'hAABB_CCDD, 3'd3, 32'h10, 1'b1);
    run("sh", 32'h0, 3'd3, 32'h12, 3);
    chk("sh_wcnt", 32'(wr_cnt - base), 32'd2);
    chk("sh_b0", wbyte(32'h1FF), 32'hDD);
    chk("sh_b1", wbyte(32'h200), 32'hCC);
    chk("sh_a0", seen_a[1], 32'h1FF);
    chk("sh_wr0", 32'(seen_wr[1]), 32'd1);

    base = wr_cnt;
    io_buffer_full = 1'b1;
    issue(ST, 3'b000, 32'h30000, 32'h0, 32'h5A,
          3'd6, 32'h60, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_in);
      if (i <= 3) chk("sb_stall_wr", 32'(mem_wr), 32'd0);
      if (i == 3) io_buffer_full = 1'b0;
      if (i == 4) begin
        chk("sb_wr", 32'(mem_wr), 32'd1);
        chk("sb_a", mem_a, 32'h30000);
        chk("sb_dout", 32'(mem_dout), 32'h5A);
      end
      if (i == 5) begin
        chk("sb_rdy", 32'(mo_rdy), 32'd1);
        chk("sb_pc", mo_completed_mo_resulting_PC,
            32'h64);
      end
    end
    chk("sb_wcnt", 32'(wr_cnt - base), 32'd1);
    chk("sb_byte", wbyte(32'h30000), 32'h5A);

    issue(LD, 3'b010, 32'h100, 32'h4, 32'h0,
          3'd7, 32'h20, 1'b0);
    @(negedge clk_in);
    @(negedge clk_in);
    flush_pipline = 1'b1;
    @(negedge clk_in);
    flush_pipline = 1'b0;
    chk("fl_busy", 32'(mo_busy), 32'd0);
    chk("fl_rdy", 32'(mo_rdy), 32'd0);
    issue(LD, 3'b000, 32'h500, 32'h0, 32'h0,
          3'd6, 32'h400, 1'b0);
    run("fl_next", 32'hFFFF_FF80, 3'd6, 32'h404, 3);

    issue(ST, 3'b010, 32'h700, 32'h0, 32'h1122_3344,
          3'd1, 32'h500, 1'b0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("mr_a",    mem_a, 32'h0);
    chk("mr_wr",   32'(mem_wr), 32'd0);
    chk("mr_dout", 32'(mem_dout), 32'd0);
    chk("mr_busy", 32'(mo_busy), 32'd0);
    chk("mr_res",  mo_res, 32'd0);
    chk("mr_id",   32'(mo_res_ins_id), 32'd0);
    chk("mr_pc",   mo_completed_mo_resulting_PC, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    issue(LD, 3'b010, 32'h100, 32'h4, 32'h0,
          3'd3, 32'h50, 1'b0);
    @(negedge clk_in);
    @(negedge clk_in);
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("hold_a", mem_a, 32'h105);
      chk("hold_rdy", 32'(mo_rdy), 32'd0);
    end
    rdy_in = 1'b1;
    run("lw_hold", 32'h1234_5678, 3'd3, 32'h54, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_operator.md
MEM_OPERATOR -- requirements
Module: mem_operator

Interface
REQ-001 Parameter: CSU_SIZE_BITS, 3, width of the instruction id tag.
REQ-002 Ports, clock and reset first:
- clk_in, in, 1, system clock; all state changes on the rising edge.
- rst_in, in, 1, reset, asynchronous and active-low.
- rdy_in, in, 1, low = freeze; all state is held and mem_wr is forced to 0.
- flush_pipline, in, 1, abort the in-flight operation.
- is_executing, in, 1, dispatch valid.
- executing_ins_type, in, 1, 1 = memory operation, 0 = not for this block.
- exec_ins_id, in, CSU_SIZE_BITS, tag returned with the result.
- exec_opcode, in, 7, 0000011 = load, 0100011 = store.
- exec_funct3, in, 3, access size and sign.
- exec_imm_val, in, 32, address offset.
- exec_rs1, in, 32, base address.
- exec_rs2, in, 32, store data.
- exec_PC, in, 32, instruction PC.
- exec_is_compressed_ins, in, 1, 1 = 16-bit instruction.
- mo_busy, out, 1, high = dispatch not accepted.
- mo_rdy, out, 1, one-cycle result valid.
- mo_res, out, 32, load result; 0 for stores.
- mo_res_ins_id, out, CSU_SIZE_BITS, tag of the completed instruction.
- mo_completed_mo_resulting_PC, out, 32, exec_PC+2 if compressed, else exec_PC+4.
- mem_din, in, 8, read byte.
- mem_dout, out, 8, write byte.
- mem_a, out, 32, byte address.
- mem_wr, out, 1, 1 = write, 0 = read.
- io_buffer_full, in, 1, UART backpressure.

Function
REQ-003 States: IDLE, ACCESS, DONE; state and all outputs are registered.
REQ-004 Accept condition: IDLE && is_executing && executing_ins_type && !flush_pipline && rdy_in.
- On accept, latch addr = exec_rs1 + exec_imm_val (mod 2^32), opcode, funct3, rs2, id and resulting PC.
- Clear byte counter k and the data accumulator; go to ACCESS.
REQ-005 mo_busy = (state != IDLE).
- A dispatch presented while busy is ignored; the CSU does not dispatch while mo_busy is high.
REQ-006 Access size N from funct3[1:0]: 00 = 1 byte, 01 = 2, 10 = 4.
- funct3[2] = 1 (LBU/LHU) zero-extends; otherwise the result is sign-extended from bit 8N-1.
- Store funct3 values 000/001/010 = SB/SH/SW.
REQ-007 Load in ACCESS, cycle k = 0..N-1:
- Drive mem_a = addr+k with mem_wr = 0.
- The byte addressed in cycle k is valid on mem_din in cycle k+1 and is captured at the end of that cycle into bits [8k+7:8k], little-endian.
- Cycle N drives mem_a = 0 and captures the last byte; the block then goes to DONE.
- LW therefore spends 5 ACCESS cycles.
REQ-008 Store in ACCESS, cycle k = 0..N-1:
- Drive mem_a = addr+k, mem_dout = rs2[8k+7:8k], mem_wr = 1.
- After byte N-1 the block goes to DONE.
REQ-009 I/O stall:
- If a store's addr[17:16] == 2'b11 and io_buffer_full is high, the cycle is a stall.
- During a stall mem_wr = 0 and k does not advance.
REQ-010 Unaligned addresses: byte accesses are issued in order; no trap.
REQ-011 DONE lasts exactly one cycle and returns to IDLE. In DONE:
- mo_rdy = 1.
- mo_res = the extended load value, or 0 for a store.
- mo_res_ins_id and mo_completed_mo_resulting_PC hold the latched values.
REQ-012 Outside DONE, mo_rdy = 0; mo_res, mo_res_ins_id and mo_completed_mo_resulting_PC hold their last value.
REQ-013 Outside store ACCESS cycles mem_wr = 0 and mem_dout = 0.
REQ-014 flush_pipline high at a clock edge, in any state:
- Next state is IDLE, mo_rdy = 0 and mem_wr = 0; no result is reported.
- Store bytes already written are not undone; stores only execute at the CSU head, so this case does not arise in normal operation.
- flush has priority over a simultaneous accept.
REQ-015 rdy_in low: state, k, accumulator and outputs are held; mem_wr = 0.
- Operation resumes at the same k when rdy_in returns high.
- A pending DONE stays asserted until the first rdy_in-high edge.
REQ-016 A non-load/store opcode accepted with type = 1 completes through DONE with mo_res = 0 and no memory access.

Reset
REQ-017 rst_in low immediately (asynchronously) sets:
- state = IDLE, k = 0, accumulator = 0.
- mo_rdy = 0, mo_res = 0, mo_res_ins_id = 0, mo_completed_mo_resulting_PC = 0.
- mem_a = 0, mem_dout = 0, mem_wr = 0; mo_busy = 0.
REQ-018 Reset asserted mid-operation discards the operation; after deassertion the first rising edge may accept a dispatch.

Verification
REQ-019 LW: rs1 = 0x100, imm = 4, memory at 0x104..0x107 = 78 56 34 12, id = 5, PC = 0x40, non-compressed ->
- mem_a reads 0x104..0x107.
- mo_rdy is high for exactly one cycle, 6 cycles after the accept edge.
- mo_res = 0x12345678, id = 5, resulting PC = 0x44.
REQ-020 LB/LBU on byte 0x80:
- LB -> mo_res = 0xFFFFFF80.
- LBU -> mo_res = 0x00000080.
- LH on 0x8001 -> mo_res = 0xFFFF8001.
REQ-021 SH: rs1 = 0x200, imm = -1, rs2 = 0xAABBCCDD, compressed, PC = 0x10 ->
- Writes DD to 0x1FF and CC to 0x200 with mem_wr = 1.
- mo_rdy with mo_res = 0, resulting PC = 0x12.
REQ-022 SB to 0x30000 with io_buffer_full held high for 3 cycles ->
- mem_wr stays 0 for those 3 cycles, then a single write occurs.
- mo_rdy one cycle later.
REQ-023 flush_pipline asserted during the second ACCESS cycle of an LW ->
- Returns to IDLE and mo_rdy never asserts.
- A dispatch on the next cycle is accepted normally.
REQ-024 rst_in pulsed low mid-SW, and rdy_in low for 4 cycles mid-LW ->
- Reset: all outputs are 0 immediately.
- rdy_in low: mem_a and k are frozen, and the LW result is unchanged and correct.
